// File: rtl/rt_ibex_pcs_restore_seq.sv
// Restore sequencer for the preemptible-context-save LIFO: captures a popped frame and
// replays it into the register file one word per cycle while the pipeline is stalled.
module rt_ibex_pcs_restore_seq #(
  parameter int unsigned                   NrSavedRegs   = 9,
  parameter int unsigned                   DataWidth     = 32,
  parameter int unsigned                   MaxDepth      = 8,
  parameter logic [NrSavedRegs-1:0][4:0]   SavedRegAddrs = {5'd14, 5'd13, 5'd12, 5'd11, 5'd10,
                                                             5'd7,  5'd6,  5'd5,  5'd1}
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             irq_ack_i,
  input  logic                             restore_en_i,
  input  logic [NrSavedRegs*DataWidth-1:0] restore_data_i,
  input  logic                             wb_busy_i,
  output logic                             stall_o,
  output logic                             rf_we_o,
  output logic [4:0]                       rf_waddr_o,
  output logic [DataWidth-1:0]             rf_wdata_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [$clog2(MaxDepth+1)-1:0]    depth_o,
  output logic                             err_o
);

  localparam int unsigned DepthW = $clog2(MaxDepth + 1);
  localparam int unsigned IdxW   = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NrSavedRegs - 1);
  localparam logic [DepthW-1:0] DepthMax = DepthW'(MaxDepth);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_WB,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q;
  logic [DataWidth-1:0]   frame_q [NrSavedRegs];
  logic [DepthW-1:0]      depth_q;
  logic                   err_q;

  logic                   capture;
  logic                   write_fire;
  logic                   last_word;
  logic                   err_d;

  // Saturating nesting-depth update; simultaneous push and pop cancel out.
  function automatic logic [DepthW-1:0] depth_step(input logic [DepthW-1:0] cur,
                                                   input logic              inc,
                                                   input logic              dec);
    depth_step = cur;
    if (inc && !dec && (cur != DepthMax)) begin
      depth_step = cur + 1'b1;
    end else if (dec && !inc) begin
      depth_step = cur - 1'b1;
    end
  endfunction

  assign busy_o    = (state_q != S_IDLE);
  assign capture   = restore_en_i && (state_q == S_IDLE) && (depth_q != '0);
  assign last_word = (idx_q == LastIdx);

  // The first write issues in the same cycle the writeback stage frees up.
  always_comb begin
    state_d    = state_q;
    write_fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (capture) state_d = S_WAIT_WB;
      end
      S_WAIT_WB: begin
        if (!wb_busy_i) begin
          write_fire = 1'b1;
          state_d    = last_word ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        write_fire = 1'b1;
        if (last_word) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    err_d = 1'b0;
    if (restore_en_i && busy_o) begin
      err_d = 1'b1;
    end else if (restore_en_i && (depth_q == '0)) begin
      err_d = 1'b1;
    end
    if (irq_ack_i && !capture && (depth_q == DepthMax)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_step(depth_q, irq_ack_i, capture);
      err_q   <= err_d;
      if (capture) begin
        idx_q <= '0;
      end else if (write_fire) begin
        idx_q <= last_word ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Frame buffer: loaded once per valid capture, before the LIFO shifts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrSavedRegs; i++) begin
        frame_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NrSavedRegs; i++) begin
        frame_q[i] <= restore_data_i[i*DataWidth +: DataWidth];
      end
    end
  end

  assign rf_we_o    = write_fire;
  assign rf_waddr_o = write_fire ? SavedRegAddrs[idx_q] : '0;
  assign rf_wdata_o = write_fire ? frame_q[idx_q] : '0;
  assign stall_o    = restore_en_i | busy_o;
  assign done_o     = (state_q == S_DONE);
  assign depth_o    = depth_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_rt_ibex_pcs_restore_seq.sv
// Directed bench for rt_ibex_pcs_restore_seq: restore timing, wb stall, depth tracking,
// protocol errors and reset during a sequence.
module tb_rt_ibex_pcs_restore_seq;

  localparam int N  = 9;
  localparam int DW = 32;
  localparam int MD = 8;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              irq_ack_i = 1'b0;
  logic              restore_en_i = 1'b0;
  logic [N*DW-1:0]   restore_data_i = '0;
  logic              wb_busy_i = 1'b0;
  logic              stall_o, rf_we_o, busy_o, done_o, err_o;
  logic [4:0]        rf_waddr_o;
  logic [DW-1:0]     rf_wdata_o;
  logic [3:0]        depth_o;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_addr [N] = '{5'd1, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};

  rt_ibex_pcs_restore_seq #(.NrSavedRegs(N), .DataWidth(DW), .MaxDepth(MD)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .irq_ack_i      (irq_ack_i),
    .restore_en_i   (restore_en_i),
    .restore_data_i (restore_data_i),
    .wb_busy_i      (wb_busy_i),
    .stall_o        (stall_o),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .depth_o        (depth_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] make_frame(input logic [31:0] base);
    logic [N*DW-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[i*DW +: DW] = base + 32'(i);
    return f;
  endfunction

  task automatic chk_write(input string tag, input int i, input logic [31:0] base);
    chk({tag, "_we"},    32'(rf_we_o), 1);
    chk({tag, "_waddr"}, 32'(rf_waddr_o), 32'(exp_addr[i]));
    chk({tag, "_wdata"}, rf_wdata_o, base + 32'(i));
    chk({tag, "_stall"}, 32'(stall_o), 1);
  endtask

  initial begin
    // reset state
    next_cyc();
    next_cyc();
    #1;
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_we",    32'(rf_we_o), 0);
    chk("rst_waddr", 32'(rf_waddr_o), 0);
    chk("rst_wdata", rf_wdata_o, 0);
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_done",  32'(done_o), 0);
    chk("rst_depth", 32'(depth_o), 0);
    chk("rst_err",   32'(err_o), 0);
    rst_ni = 1'b1;
    next_cyc();

    // 1: basic restore at depth 1
    irq_ack_i = 1'b1;
    next_cyc();
    irq_ack_i = 1'b0;
    #1;
    chk("t1_depth_pre", 32'(depth_o), 1);
    next_cyc();
    restore_en_i = 1'b1;
    restore_data_i = make_frame(32'h100);
    #1;
    chk("t1_stall_T", 32'(stall_o), 1);
    chk("t1_we_T",    32'(rf_we_o), 0);
    chk("t1_busy_T",  32'(busy_o), 0);
    next_cyc();
    restore_en_i = 1'b0;
    restore_data_i = '0;
    for (int i = 0; i < N; i++) begin
      #1;
      chk_write("t1", i, 32'h100);
      chk("t1_done_w", 32'(done_o), 0);
      next_cyc();
    end
    #1;
    chk("t1_done",      32'(done_o), 1);
    chk("t1_we_done",   32'(rf_we_o), 0);
    chk("t1_stall_done", 32'(stall_o), 1);
    chk("t1_depth",     32'(depth_o), 0);
    next_cyc();
    #1;
    chk("t1_done_low", 32'(done_o), 0);
    chk("t1_busy_end", 32'(busy_o), 0);
    chk("t1_stall_end", 32'(stall_o), 0);

    // 2: writeback busy for 3 cycles after the pulse
    irq_ack_i = 1'b1;
    next_cyc();
    irq_ack_i = 1'b0;
    restore_en_i = 1'b1;
    restore_data_i = make_frame(32'h200);
    next_cyc();
    restore_en_i = 1'b0;
    restore_data_i = '0;
    wb_busy_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_we_wait",    32'(rf_we_o), 0);
      chk("t2_stall_wait", 32'(stall_o), 1);
      chk("t2_busy_wait",  32'(busy_o), 1);
      next_cyc();
    end
    wb_busy_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      #1;
      chk_write("t2", i, 32'h200);
      next_cyc();
    end
    #1;
    chk("t2_done",  32'(done_o), 1);
    chk("t2_depth", 32'(depth_o), 0);
    next_cyc();

    // 3: restore with nothing saved
    restore_en_i = 1'b1;
    restore_data_i = make_frame(32'h555);
    #1;
    chk("t3_we_T", 32'(rf_we_o), 0);
    next_cyc();
    restore_en_i = 1'b0;
    #1;
    chk("t3_err",   32'(err_o), 1);
    chk("t3_busy",  32'(busy_o), 0);
    chk("t3_we",    32'(rf_we_o), 0);
    chk("t3_depth", 32'(depth_o), 0);
    next_cyc();
    #1;
    chk("t3_err_pulse", 32'(err_o), 0);
    chk("t3_busy2",     32'(busy_o), 0);
    chk("t3_we2",       32'(rf_we_o), 0);

    // 4: nine acks against depth 8
    for (int k = 0; k < 9; k++) begin
      irq_ack_i = 1'b1;
      next_cyc();
      #1;
      chk("t4_depth", 32'(depth_o), (k < 8) ? k + 1 : 8);
      chk("t4_err",   32'(err_o), (k == 8) ? 1 : 0);
    end
    irq_ack_i = 1'b0;
    next_cyc();
    #1;
    chk("t4_err_clr",   32'(err_o), 0);
    chk("t4_depth_hold", 32'(depth_o), 8);

    // 5: second pulse during the writes is rejected
    restore_en_i = 1'b1;
    restore_data_i = make_frame(32'h300);
    next_cyc();
    restore_en_i = 1'b0;
    restore_data_i = '0;
    for (int i = 0; i < N; i++) begin
      if (i == 3) begin
        restore_en_i = 1'b1;
        restore_data_i = make_frame(32'h999);
      end else begin
        restore_en_i = 1'b0;
        restore_data_i = '0;
      end
      #1;
      chk_write("t5", i, 32'h300);
      chk("t5_err", 32'(err_o), (i == 4) ? 1 : 0);
      next_cyc();
    end
    #1;
    chk("t5_done",  32'(done_o), 1);
    chk("t5_depth", 32'(depth_o), 7);
    next_cyc();

    // 6: reset in the middle of a sequence
    restore_en_i = 1'b1;
    restore_data_i = make_frame(32'h400);
    next_cyc();
    restore_en_i = 1'b0;
    restore_data_i = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_write("t6", i, 32'h400);
      next_cyc();
    end
    rst_ni = 1'b0;
    #1;
    chk("t6_we",    32'(rf_we_o), 0);
    chk("t6_waddr", 32'(rf_waddr_o), 0);
    chk("t6_wdata", rf_wdata_o, 0);
    chk("t6_stall", 32'(stall_o), 0);
    chk("t6_busy",  32'(busy_o), 0);
    chk("t6_done",  32'(done_o), 0);
    chk("t6_depth", 32'(depth_o), 0);
    chk("t6_err",   32'(err_o), 0);
    next_cyc();
    rst_ni = 1'b1;
    for (int k = 0; k < 10; k++) begin
      next_cyc();
      #1;
      chk("t6_we_after",   32'(rf_we_o), 0);
      chk("t6_busy_after", 32'(busy_o), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
